// File: rtl/fir_filter_param_if.sv
// Sample, coefficient-load and result signals of the parametrised FIR filter.
interface fir_filter_param_if #(
  parameter int DW = 10,
  parameter int CW = 8,
  parameter int AW = 3,
  parameter int OW = 24
);
  logic                 clr;
  logic                 in_valid;
  logic signed [DW-1:0] data_in;
  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 out_valid;
  logic signed [OW-1:0] data_out;

  modport slave (
    input  clr, in_valid, data_in, coef_we, coef_addr, coef_data,
    output out_valid, data_out
  );

  modport master (
    output clr, in_valid, data_in, coef_we, coef_addr, coef_data,
    input  out_valid, data_out
  );
endinterface

// File: rtl/fir_filter_param.sv
// Direct-form FIR: sample delay line, registered per-tap products, registered adder tree.
// Runtime-loadable coefficients; clr flushes history and pipeline but keeps coefficients.
module fir_filter_param #(
  parameter int DW   = 10,
  parameter int CW   = 8,
  parameter int TAPS = 8,
  parameter int OW   = 24,
  parameter int AW   = 3
) (
  input  logic clk,
  input  logic rst,
  fir_filter_param_if.slave bus
);

  localparam int PW = DW + CW;
  localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [AW:0] TAPS_W = (AW+1)'(TAPS);

  logic signed [DW-1:0] x    [TAPS];
  logic signed [CW-1:0] coef [TAPS];
  logic signed [PW-1:0] prod [TAPS];
  logic                 v0;
  logic                 v1;
  logic signed [OW-1:0] sum;

  // Products are sign-extended to OW before adding, so the sum is exact.
  always_comb begin
    sum = '0;
    for (int k = 0; k < TAPS; k++) begin
      sum = sum + OW'(prod[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        x[k]    <= '0;
        coef[k] <= '0;
        prod[k] <= '0;
      end
      v0            <= 1'b0;
      v1            <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.data_out  <= '0;
    end else begin
      if (bus.coef_we && ({1'b0, bus.coef_addr} < TAPS_W)) begin
        coef[bus.coef_addr[IW-1:0]] <= bus.coef_data;
      end

      if (bus.clr) begin
        for (int k = 0; k < TAPS; k++) begin
          x[k]    <= '0;
          prod[k] <= '0;
        end
        v0            <= 1'b0;
        v1            <= 1'b0;
        bus.out_valid <= 1'b0;
      end else begin
        if (bus.in_valid) begin
          x[0] <= bus.data_in;
          for (int k = 1; k < TAPS; k++) begin
            x[k] <= x[k-1];
          end
        end
        v0 <= bus.in_valid;

        if (v0) begin
          for (int k = 0; k < TAPS; k++) begin
            prod[k] <= PW'(x[k]) * PW'(coef[k]);
          end
        end
        v1 <= v0;

        bus.out_valid <= v1;
        if (v1) begin
          bus.data_out <= sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_filter_param.sv
// Directed bench for fir_filter_param: table-driven vectors plus hand-written corner sequences.
module tb_fir_filter_param;

  localparam int DW = 10;
  localparam int CW = 8;
  localparam int TAPS = 8;
  localparam int OW = 24;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_filter_param_if #(.DW(DW), .CW(CW), .AW(AW), .OW(OW)) bus ();

  fir_filter_param #(.DW(DW), .CW(CW), .TAPS(TAPS), .OW(OW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic                 clr;
    logic                 iv;
    logic signed [DW-1:0] d;
    logic                 we;
    logic [AW-1:0]        a;
    logic signed [CW-1:0] cd;
    logic                 ov;
    logic signed [OW-1:0] dout;
  } vec_t;

  vec_t tbl [$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   imp_lo, imp_hi, gap_lo, gap_hi, upd_lo, upd_hi;

  function automatic vec_t mk(input logic c, input logic iv, input int d, input logic we,
                              input int a, input int cd, input logic ov, input int dout);
    vec_t v;
    v.clr  = c;
    v.iv   = iv;
    v.d    = DW'(d);
    v.we   = we;
    v.a    = AW'(a);
    v.cd   = CW'(cd);
    v.ov   = ov;
    v.dout = OW'(dout);
    return v;
  endfunction

  task automatic step(input logic r, input logic c, input logic iv, input int d,
                      input logic we, input int a, input int cd);
    rst           = r;
    bus.clr       = c;
    bus.in_valid  = iv;
    bus.data_in   = DW'(d);
    bus.coef_we   = we;
    bus.coef_addr = AW'(a);
    bus.coef_data = CW'(cd);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic ev, input logic signed [OW-1:0] ed);
    n_vec++;
    if (bus.out_valid !== ev || bus.data_out !== ed) begin
      n_bad++;
      $display("FAIL %s: got out_valid=%0b data_out=%0d, want out_valid=%0b data_out=%0d",
               name, bus.out_valid, bus.data_out, ev, ed);
    end
  endtask

  task automatic run_rows(input string name, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      step(1'b0, tbl[i].clr, tbl[i].iv, int'(tbl[i].d), tbl[i].we, int'(tbl[i].a),
           int'(tbl[i].cd));
      chk($sformatf("%s[%0d]", name, i - lo), tbl[i].ov, tbl[i].dout);
    end
  endtask

  task automatic load_all(input int val);
    for (int k = 0; k < TAPS; k++) step(1'b0, 1'b0, 1'b0, 0, 1'b1, k, val);
  endtask

  initial begin
    // Impulse: coef[k]=k+1, then 1 followed by 10 zeros back-to-back.
    imp_lo = tbl.size();
    for (int k = 0; k < TAPS; k++) tbl.push_back(mk(0, 0, 0, 1, k, k + 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    for (int n = 0; n < 11; n++)
      tbl.push_back(mk(0, (n < 9) ? 1'b1 : 1'b0, 0, 0, 0, 0, 1, (n < 8) ? n + 1 : 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    imp_hi = tbl.size();

    // Gapped stream with coef[0]=1 only: 5, gap, 7, gap, gap, 9.
    gap_lo = tbl.size();
    for (int k = 0; k < TAPS; k++) tbl.push_back(mk(0, 0, 0, 1, k, (k == 0) ? 1 : 0, 0, 0));
    tbl.push_back(mk(0, 1, 5, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 7, 0, 0, 0, 1, 5));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 7));
    tbl.push_back(mk(0, 1, 9, 0, 0, 0, 0, 7));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 9));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 9));
    gap_hi = tbl.size();

    // Coefficient update on the same edge as a sample, then out-of-range writes.
    upd_lo = tbl.size();
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 9));
    tbl.push_back(mk(0, 1, 2, 1, 0, 3, 0, 9));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 6));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 6));
    tbl.push_back(mk(0, 0, 0, 1, 8, 5, 0, 6));
    tbl.push_back(mk(0, 0, 0, 1, 15, 100, 0, 6));
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 6));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 6));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 6));
    upd_hi = tbl.size();

    step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    chk("reset", 1'b0, '0);

    run_rows("impulse", imp_lo, imp_hi);
    run_rows("gapped", gap_lo, gap_hi);
    run_rows("coef_update", upd_lo, upd_hi);

    // Extreme magnitude: coef=-128, eight samples of -512 then eight of 511.
    step(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 0);
    load_all(-128);
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 1'b0, (i < 16) ? 1'b1 : 1'b0, (i < 8) ? -512 : 511, 1'b0, 0, 0);
      if (i >= 2) begin
        int j, m, e;
        j = i - 2;
        if (j < 8) e = (j + 1) * 65536;
        else begin
          m = j - 7;
          e = (8 - m) * 65536 + m * (511 * -128);
        end
        chk($sformatf("extreme[%0d]", j), 1'b1, OW'(e));
      end
    end

    // clr while a sample is in flight: result suppressed, data_out held, history gone.
    step(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 0);
    load_all(1);
    step(1'b0, 1'b0, 1'b1, 1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b1, 2, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b1, 3, 1'b0, 0, 0);
    chk("clr_pre", 1'b1, 24'sd1);
    step(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 0);
    chk("clr_edge", 1'b0, 24'sd1);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    chk("clr_hold1", 1'b0, 24'sd1);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    chk("clr_hold2", 1'b0, 24'sd1);
    step(1'b0, 1'b0, 1'b1, 4, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    chk("clr_after", 1'b1, 24'sd4);
    // A sample on the same edge as clr is dropped.
    step(1'b0, 1'b1, 1'b1, 100, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b1, 5, 1'b0, 0, 0);
    chk("clr_drop_gap", 1'b0, 24'sd4);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    chk("clr_drop", 1'b1, 24'sd5);

    // Reset in the middle of back-to-back streaming.
    step(1'b0, 1'b0, 1'b1, 1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b1, 2, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b1, 3, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b1, 4, 1'b0, 0, 0);
    chk("rst_mid", 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    chk("rst_idle1", 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    chk("rst_idle2", 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 7, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    chk("rst_coef_zero", 1'b1, '0);
    step(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 0);
    run_rows("impulse_again", imp_lo, imp_hi);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
